ifetch_resp: RTL and testbench



---
 rtl/ifetch_resp.sv | 185 ++++++++++++++++++
 tb/tb_ifetch_resp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_resp.sv
// ifetch_resp -- instruction-fetch responder between the PC register and the
// instruction bus. Hits in the holding entry return the instruction in the
// same cycle. A miss raises stallreq_o and fetches the word over a
// request/grant/response bus, with at most one transaction outstanding.
//
// Optional feature macro: IFETCH_PREFETCH_EN
//   When defined, a second holding entry is added. A hit in IDLE prefetches
//   pc_i+4 into the other entry.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ce_i, pc_i    fetch enable and fetch address from the PC register
//   inst_o        instruction for pc_i (NOP when misaligned, 0 otherwise)
//   stallreq_o    instruction not yet available; the PC must hold
//   misalign_o    ce_i=1 and pc_i[1:0]!=0
//   mem_req_o     bus request (registered)
//   mem_addr_o    bus word address (registered, stable while mem_req_o=1)
//   mem_gnt_i     request accepted this cycle
//   mem_rvalid_i  response data valid (ignored outside WAIT)
//   mem_rdata_i   response data
module ifetch_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

`ifdef IFETCH_PREFETCH_EN
    localparam int NUM_ENT = 2;
`else
    localparam int NUM_ENT = 1;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                     state, state_nxt;
    logic                       req_nxt;
    logic [31:0]                addr_nxt;
    logic                       tgt, tgt_nxt;     // entry the in-flight fill writes
    logic                       demand_tgt;

    logic [NUM_ENT-1:0]         ent_vld;
    logic [NUM_ENT-1:0][31:0]   ent_addr;
    logic [NUM_ENT-1:0][31:0]   ent_data;

    logic                       aligned, fetch, hit, miss, fill;
    logic [NUM_ENT-1:0]         hit_vec;
    logic [31:0]                hit_data;

    assign aligned = (pc_i[1:0] == 2'b00);
    assign fetch   = ce_i & aligned;
    assign fill    = (state == WAIT) & mem_rvalid_i;

    always_comb begin
        hit_vec  = '0;
        hit_data = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            hit_vec[i] = ent_vld[i] && (ent_addr[i] == pc_i);
            if (hit_vec[i]) hit_data = ent_data[i];
        end
    end

    assign hit  = fetch & (|hit_vec);
    assign miss = fetch & ~(|hit_vec);

`ifdef IFETCH_PREFETCH_EN
    logic        last_hit;   // entry holding the most recent hit
    logic        hit_idx;
    logic [31:0] pf_addr;
    logic        pf_have, pf_go;

    assign hit_idx    = hit_vec[1];
    assign pf_addr    = pc_i + 32'd4;   // wraps mod 2^32
    assign demand_tgt = ~last_hit;      // keep the most recently used entry

    always_comb begin
        pf_have = 1'b0;
        for (int i = 0; i < NUM_ENT; i++)
            if (ent_vld[i] && (ent_addr[i] == pf_addr)) pf_have = 1'b1;
    end

    assign pf_go = hit & ~pf_have;

    always_ff @(posedge clk) begin
        if (rst)      last_hit <= 1'b0;
        else if (hit) last_hit <= hit_idx;
    end
`else
    assign demand_tgt = 1'b0;
`endif

    // Responses to the PC side are purely combinational.
    always_comb begin
        inst_o     = '0;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        if (ce_i) begin
            if (!aligned) begin
                inst_o     = NOP;
                misalign_o = 1'b1;
            end else if (hit) begin
                inst_o = hit_data;
            end else begin
                stallreq_o = 1'b1;
            end
        end
    end

    // Bus FSM. A redirect mid-fetch does not abort: the fill lands under its
    // own address and the tag compare in IDLE raises the new miss.
    always_comb begin
        state_nxt = state;
        req_nxt   = mem_req_o;
        addr_nxt  = mem_addr_o;
        tgt_nxt   = tgt;
        case (state)
            IDLE: begin
                if (miss) begin
                    addr_nxt  = pc_i;
                    req_nxt   = 1'b1;
                    tgt_nxt   = demand_tgt;
                    state_nxt = REQ;
                end
`ifdef IFETCH_PREFETCH_EN
                else if (pf_go) begin
                    addr_nxt  = pf_addr;
                    req_nxt   = 1'b1;
                    tgt_nxt   = ~hit_idx;
                    state_nxt = REQ;
                end
`endif
            end
            REQ: begin
                if (mem_gnt_i) begin
                    req_nxt   = 1'b0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) state_nxt = IDLE;
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            tgt        <= 1'b0;
            ent_vld    <= '0;
        end else begin
            state      <= state_nxt;
            mem_req_o  <= req_nxt;
            mem_addr_o <= addr_nxt;
            tgt        <= tgt_nxt;
            for (int i = 0; i < NUM_ENT; i++)
                if (fill && (tgt == 1'(i))) ent_vld[i] <= 1'b1;
        end
    end

    // Tag/data need no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENT; i++) begin
            if (fill && (tgt == 1'(i))) begin
                ent_addr[i] <= mem_addr_o;
                ent_data[i] <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_resp.sv
// Self-checking bench for ifetch_resp. A bus-slave process serves requests
// with programmable grant/response delay; expected bus addresses and
// expected instructions are queued when stimulus is driven and popped when
// the DUT issues a request or delivers an instruction.
module tb_ifetch_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        stallreq, misalign, mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int gnt_delay = 0;
    int rv_delay  = 0;

    logic [31:0] req_q[$];
    logic [31:0] inst_q[$];

    always #5 clk = ~clk;

    ifetch_resp dut (
        .clk(clk), .rst(rst), .ce_i(ce), .pc_i(pc),
        .inst_o(inst), .stallreq_o(stallreq), .misalign_o(misalign),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : ((a ^ 32'h5A5A_0000) + 32'h13);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus slave: drives gnt/rvalid at negedge, checks request addresses.
    initial begin
        logic [31:0] cur_addr, gnt_addr;
        logic        seen, pend;
        int          gcnt, rcnt;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        seen = 1'b0; pend = 1'b0; gcnt = 0; rcnt = 0;
        cur_addr = '0; gnt_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                seen = 1'b0; pend = 1'b0; gcnt = 0;
            end else begin
                mem_rvalid = 1'b0;
                if (pend) begin
                    if (rcnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem_word(gnt_addr);
                        pend       = 1'b0;
                    end else rcnt--;
                end
                mem_gnt = 1'b0;
                if (mem_req) begin
                    if (!seen) begin
                        seen = 1'b1;
                        cur_addr = mem_addr;
                        chk("req_expected", 32'(req_q.size() != 0), 32'd1);
                        if (req_q.size() != 0) chk("req_addr", mem_addr, req_q.pop_front());
                    end else begin
                        chk("addr_hold", mem_addr, cur_addr);
                    end
                    if (gcnt == gnt_delay) begin
                        mem_gnt  = 1'b1;
                        gnt_addr = mem_addr;
                        pend     = 1'b1;
                        rcnt     = rv_delay;
                        gcnt     = 0;
                    end else gcnt++;
                end else begin
                    seen = 1'b0;
                    gcnt = 0;
                end
            end
        end
    end

    task automatic wait_inst(input int exp_stalls);
        int stalls = 0;
        @(negedge clk);
        while (stallreq && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        chk("stall_timeout", 32'(stallreq), 32'd0);
        chk("stalls", 32'(stalls), 32'(exp_stalls));
        chk("inst", inst, inst_q.pop_front());
    endtask

    task automatic do_fetch(input logic [31:0] a, input int exp_stalls, input bit is_miss);
        if (is_miss) req_q.push_back(a);
        inst_q.push_back(mem_word(a));
        @(posedge clk); #1;
        pc = a; ce = 1'b1;
        wait_inst(exp_stalls);
    endtask

    task automatic hold(input int n, input bit noreq);
        repeat (n) begin
            @(negedge clk);
            chk("hold_stall", 32'(stallreq), 32'd0);
            chk("hold_inst", inst, mem_word(pc));
            if (noreq) chk("hold_noreq", 32'(mem_req), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst", inst, 32'h0);
        chk("rst_stall", 32'(stallreq), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

`ifdef IFETCH_PREFETCH_EN
        // Sequential stream: only the first word stalls.
        do_fetch(32'h0, 3, 1'b1);
        req_q.push_back(32'h4);
        hold(3, 1'b0);
        do_fetch(32'h4, 0, 1'b0);
        req_q.push_back(32'h8);
        hold(3, 1'b0);
        do_fetch(32'h8, 0, 1'b0);
        req_q.push_back(32'hC);
        hold(3, 1'b0);
        // Prefetch target wraps to 0.
        do_fetch(32'hFFFF_FFFC, 3, 1'b1);
        req_q.push_back(32'h0);
        hold(3, 1'b0);
        do_fetch(32'h0, 0, 1'b0);
        req_q.push_back(32'h4);
        hold(3, 1'b0);
`else
        // Cold miss, gnt with req, rvalid next cycle.
        do_fetch(32'h0, 3, 1'b1);
        hold(4, 1'b1);

        // Grant delayed by 4 cycles.
        gnt_delay = 4;
        do_fetch(32'h20, 7, 1'b1);
        gnt_delay = 0;

        // Redirect 0x10 -> 0x40 while in WAIT.
        rv_delay = 3;
        req_q.push_back(32'h10);
        req_q.push_back(32'h40);
        inst_q.push_back(mem_word(32'h40));
        @(posedge clk); #1 pc = 32'h10; ce = 1'b1;
        repeat (2) @(posedge clk);
        #1 pc = 32'h40;
        wait_inst(10);
        rv_delay = 0;

        // Misaligned: NOP, no request.
        @(posedge clk); #1 pc = 32'h2; ce = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mis_inst", inst, 32'h0000_0013);
            chk("mis_flag", 32'(misalign), 32'd1);
            chk("mis_stall", 32'(stallreq), 32'd0);
            chk("mis_noreq", 32'(mem_req), 32'd0);
        end

        // Disabled fetch.
        @(posedge clk); #1 ce = 1'b0;
        @(negedge clk);
        chk("ce0_inst", inst, 32'h0);
        chk("ce0_stall", 32'(stallreq), 32'd0);
        chk("ce0_misalign", 32'(misalign), 32'd0);

        // Reset while in REQ, then the old line must miss again.
        gnt_delay = 10;
        @(posedge clk); #1 pc = 32'h80; ce = 1'b1;
        @(posedge clk); #1;
        chk("req_before_rst", 32'(mem_req), 32'd1);
        rst = 1'b1; ce = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        gnt_delay = 0;
        do_fetch(32'h40, 3, 1'b1);
`endif
        repeat (3) @(posedge clk);
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
